// File: rtl/gusn_pkg.sv
// rtl/gusn_pkg.sv - shared types, image geometry and counter width helper for the frame loader
package gusn_pkg;

  typedef enum logic [1:0] {IDLE, ACK, RUN, DONE} issue_state_t;

  localparam int IMG_ROW_W = 5;
  localparam int IMG_ROWS  = 5;
  localparam int IMG_WIDTH = 25;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - fill side: packs row beats into the shadow frame and tracks sof resync
module row_assembler
  import gusn_pkg::*;
#(
  parameter int ROW_W = IMG_ROW_W,
  parameter int ROWS  = IMG_ROWS,
  parameter int WIDTH = IMG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  input  logic             row_sof,
  input  logic             take,
  input  logic             err_clr,
  output logic             row_ready,
  output logic [WIDTH-1:0] shadow,
  output logic             shadow_full,
  output logic             err_sync
);

  localparam int IW = cnt_w(ROWS);

  logic [IW-1:0] row_idx;
  logic [IW-1:0] wr_row;
  logic          beat;
  logic          resync;
  logic          last;

  assign row_ready = !shadow_full;
  assign beat      = row_valid && row_ready;
  // A sof beat in the middle of a frame restarts the frame with this beat as row 0.
  assign resync    = row_sof && (row_idx != '0);
  assign wr_row    = resync ? '0 : row_idx;
  assign last      = !resync && (row_idx == IW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx     <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      err_sync    <= 1'b0;
    end else begin
      if (take) begin
        shadow_full <= 1'b0;
      end
      if (beat) begin
        shadow[WIDTH - 1 - int'(wr_row) * ROW_W -: ROW_W] <= row_data;
        if (last) begin
          row_idx     <= '0;
          shadow_full <= 1'b1;
        end else if (resync) begin
          row_idx <= IW'(1);
        end else begin
          row_idx <= row_idx + IW'(1);
        end
      end
      if (beat && resync) begin
        err_sync <= 1'b1;
      end else if (err_clr) begin
        err_sync <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - double-buffered image loader issuing packed frames to the perceptron
module frame_loader
  import gusn_pkg::*;
#(
  parameter int ROW_W   = IMG_ROW_W,
  parameter int ROWS    = IMG_ROWS,
  parameter int WIDTH   = IMG_WIDTH,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  input  logic             row_sof,
  output logic             row_ready,
  output logic [WIDTH-1:0] p_in,
  output logic             p_en,
  input  logic             p_ready,
  input  logic             err_clr,
  output logic [7:0]       frame_cnt,
  output logic             err_sync,
  output logic             err_tmo,
  output logic             busy
);

  localparam int TW = cnt_w(TIMEOUT);

  issue_state_t     state;
  issue_state_t     state_nxt;
  logic [TW-1:0]    tmo_cnt;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic             take;
  logic             finish;
  logic             expire;
  logic             waiting;

  row_assembler #(
    .ROW_W(ROW_W),
    .ROWS (ROWS),
    .WIDTH(WIDTH)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_sof    (row_sof),
    .take       (take),
    .err_clr    (err_clr),
    .row_ready  (row_ready),
    .shadow     (shadow),
    .shadow_full(shadow_full),
    .err_sync   (err_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (shadow_full) state_nxt = ACK;
      ACK: begin
        if (expire)        state_nxt = IDLE;
        else if (!p_ready) state_nxt = RUN;
      end
      RUN: begin
        if (finish)      state_nxt = DONE;
        else if (expire) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A completion seen on the last allowed cycle still counts as a good frame.
  always_comb begin
    waiting = (state == ACK) || (state == RUN);
    take    = (state == IDLE) && shadow_full;
    finish  = (state == RUN) && p_ready;
    expire  = waiting && !finish && (tmo_cnt == TW'(TIMEOUT - 1));
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_in      <= '0;
      p_en      <= 1'b0;
      frame_cnt <= '0;
      err_tmo   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (take) begin
        p_in    <= shadow;
        p_en    <= 1'b1;
        tmo_cnt <= '0;
      end else if (waiting) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (finish || expire) begin
        p_en <= 1'b0;
      end
      if (finish) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (expire) begin
        err_tmo <= 1'b1;
      end else if (err_clr) begin
        err_tmo <= 1'b0;
      end
    end
  end

endmodule
